// File: rtl/lab3_pkg.sv
// Shared definitions for the vote collector: ballot width and FSM state encoding.
package lab3_pkg;

    // Ballot width; the downstream majority stage is built for exactly five voters.
    localparam int NUM_VOTERS = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2
    } state_t;

endpackage

// File: rtl/vote_timer.sv
// Saturating collection timer: counts while enabled, flags the final allowed cycle.
module vote_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Next count: clear wins, otherwise step while enabled and hold at LAST so it never wraps.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/vote_collector.sv
// Collects one vote per voter into a ballot, presents it downstream, and forces it
// out with a timeout flag if voters are missing when the collection window closes.
module vote_collector
    import lab3_pkg::*;
#(
    parameter int NUM_VOTERS     = lab3_pkg::NUM_VOTERS,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  abort,
    input  logic                  vote_valid,
    input  logic [2:0]            vote_id,
    input  logic                  vote_bit,
    output logic                  vote_ready,
    output logic [NUM_VOTERS-1:0] ballot,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  timed_out,
    output logic                  err
);

    state_t                state_q;
    logic [NUM_VOTERS-1:0] ballot_q;
    logic [NUM_VOTERS-1:0] ballot_d;
    logic [NUM_VOTERS-1:0] received_q;
    logic [NUM_VOTERS-1:0] received_d;
    logic                  out_valid_q;
    logic                  timed_out_q;
    logic                  err_q;

    logic [NUM_VOTERS-1:0] id_hot;
    logic                  id_ok;
    logic                  dup;
    logic                  offered;
    logic                  accept;
    logic                  reject;
    logic                  complete;
    logic                  timer_clear;
    logic                  timer_enable;
    logic                  timer_expired;

    // One-hot decode of the voter index; ids outside the ballot decode to all zeros.
    generate
        for (genvar gi = 0; gi < NUM_VOTERS; gi++) begin : g_id_hot
            assign id_hot[gi] = (vote_id == 3'(gi));
        end
    endgenerate

    // Vote qualification and the ballot/received values an accepted vote would produce.
    always_comb begin
        id_ok      = |id_hot;
        dup        = |(id_hot & received_q);
        offered    = vote_valid && (state_q != PRESENT);
        accept     = offered && id_ok && !dup;
        reject     = offered && !accept;
        received_d = received_q;
        ballot_d   = ballot_q;
        if (accept) begin
            received_d = received_q | id_hot;
            ballot_d   = (ballot_q & ~id_hot) | (vote_bit ? id_hot : '0);
        end
        complete = &received_d;
    end

    // Timer only runs in COLLECT and sits at zero everywhere else, so entry into COLLECT starts from 0.
    assign timer_clear  = abort || (state_q != COLLECT);
    assign timer_enable = (state_q == COLLECT);

    vote_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // Main FSM with registered outputs; abort outranks every other event, and completion outranks timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ballot_q    <= '0;
            received_q  <= '0;
            out_valid_q <= 1'b0;
            timed_out_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (abort) begin
            state_q     <= IDLE;
            ballot_q    <= '0;
            received_q  <= '0;
            out_valid_q <= 1'b0;
            timed_out_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= reject;
            case (state_q)
                IDLE: begin
                    ballot_q   <= ballot_d;
                    received_q <= received_d;
                    if (accept) begin
                        if (complete) begin
                            state_q     <= PRESENT;
                            out_valid_q <= 1'b1;
                            timed_out_q <= 1'b0;
                        end else begin
                            state_q <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    ballot_q   <= ballot_d;
                    received_q <= received_d;
                    if (complete) begin
                        state_q     <= PRESENT;
                        out_valid_q <= 1'b1;
                        timed_out_q <= 1'b0;
                    end else if (timer_expired) begin
                        state_q     <= PRESENT;
                        out_valid_q <= 1'b1;
                        timed_out_q <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        ballot_q    <= '0;
                        received_q  <= '0;
                        out_valid_q <= 1'b0;
                        timed_out_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    ballot_q    <= '0;
                    received_q  <= '0;
                    out_valid_q <= 1'b0;
                    timed_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign vote_ready = (state_q != PRESENT);
    assign ballot     = ballot_q;
    assign out_valid  = out_valid_q;
    assign timed_out  = timed_out_q;
    assign err        = err_q;

endmodule

// File: tb/tb_vote_collector.sv
// Scoreboard bench for vote_collector: expected ballots are queued as votes are
// driven and compared when the DUT presents them.
module tb_vote_collector;

    typedef struct {
        logic [4:0] ballot;
        logic       timed_out;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       abort;
    logic       vote_valid;
    logic [2:0] vote_id;
    logic       vote_bit;
    logic       vote_ready;
    logic [4:0] ballot;
    logic       out_valid;
    logic       out_ready;
    logic       timed_out;
    logic       err;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n;
    logic seen;
    logic [4:0] bits;

    vote_collector #(
        .NUM_VOTERS     (5),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .abort      (abort),
        .vote_valid (vote_valid),
        .vote_id    (vote_id),
        .vote_bit   (vote_bit),
        .vote_ready (vote_ready),
        .ballot     (ballot),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .timed_out  (timed_out),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vote(input logic [2:0] id, input logic b);
        vote_valid = 1'b1;
        vote_id    = id;
        vote_bit   = b;
        tick();
        vote_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int cnt);
        cnt = 0;
        while (!out_valid && cnt < max) begin
            tick();
            cnt++;
        end
        check_eq("wait_valid", out_valid, 1);
    endtask

    task automatic push_exp(input logic [4:0] b, input logic to);
        exp_t e;
        e.ballot    = b;
        e.timed_out = to;
        sb.push_back(e);
    endtask

    task automatic consume(input string tag);
        exp_t e;
        e.ballot    = 5'h1f;
        e.timed_out = 1'b1;
        if (sb.size() > 0) e = sb.pop_front();
        check_eq({tag, "_out_valid"}, out_valid, 1);
        check_eq({tag, "_ballot"}, ballot, e.ballot);
        check_eq({tag, "_timed_out"}, timed_out, e.timed_out);
        $display("ballot %s: ballot=%b timed_out=%0d", tag, ballot, timed_out);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_after_valid"}, out_valid, 0);
        check_eq({tag, "_after_ballot"}, ballot, 0);
        check_eq({tag, "_after_ready"}, vote_ready, 1);
    endtask

    initial begin
        reset_n    = 1'b0;
        abort      = 1'b0;
        vote_valid = 1'b0;
        vote_id    = 3'd0;
        vote_bit   = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        check_eq("rst_ready", vote_ready, 1);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_ballot", ballot, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_timed_out", timed_out, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Full ballot on consecutive cycles.
        bits = 5'b01101;
        push_exp(5'b01101, 1'b0);
        for (int i = 0; i < 5; i++) begin
            vote(3'(i), bits[i]);
            if (i == 3) check_eq("full_not_yet", out_valid, 0);
        end
        check_eq("full_latency", out_valid, 1);
        check_eq("full_ready_low", vote_ready, 0);
        consume("full");

        // Duplicate and out-of-range votes, then timeout.
        push_exp(5'b00100, 1'b1);
        vote(3'd2, 1'b1);
        check_eq("dup_first_err", err, 0);
        vote(3'd2, 1'b0);
        check_eq("dup_err", err, 1);
        check_eq("dup_keeps_bit", ballot, 5'b00100);
        vote(3'd7, 1'b1);
        check_eq("badid_err", err, 1);
        tick();
        check_eq("err_single_pulse", err, 0);
        wait_valid(40, n);
        check_eq("dup_timeout_cycles", n + 1, 14);
        consume("dup");

        // Partial ballot times out after 16 COLLECT cycles.
        push_exp(5'b00011, 1'b1);
        vote(3'd0, 1'b1);
        vote(3'd1, 1'b1);
        wait_valid(40, n);
        check_eq("partial_timeout_cycles", n, 15);
        consume("partial");

        // Backpressure: held PRESENT ignores votes.
        bits = 5'b01010;
        push_exp(5'b01010, 1'b0);
        for (int i = 0; i < 5; i++) vote(3'(i), bits[i]);
        for (int i = 0; i < 10; i++) begin
            vote_valid = 1'b1;
            vote_id    = (i % 2 == 0) ? 3'd0 : 3'd6;
            vote_bit   = 1'b1;
            tick();
            check_eq("hold_ballot", ballot, 5'b01010);
            check_eq("hold_ready", vote_ready, 0);
            check_eq("hold_err", err, 0);
            check_eq("hold_valid", out_valid, 1);
        end
        vote_valid = 1'b0;
        consume("hold");

        // Abort during COLLECT with a coincident vote.
        vote(3'd0, 1'b1);
        vote(3'd1, 1'b1);
        vote(3'd2, 1'b1);
        check_eq("pre_abort_ballot", ballot, 5'b00111);
        abort      = 1'b1;
        vote_valid = 1'b1;
        vote_id    = 3'd3;
        vote_bit   = 1'b1;
        tick();
        abort      = 1'b0;
        vote_valid = 1'b0;
        check_eq("abort_ballot", ballot, 0);
        check_eq("abort_ready", vote_ready, 1);
        check_eq("abort_err", err, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen = seen | out_valid;
            tick();
        end
        check_eq("abort_no_valid", seen, 0);

        // Reset during PRESENT discards the ballot.
        for (int i = 0; i < 5; i++) vote(3'(i), 1'b1);
        check_eq("prerst_valid", out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", out_valid, 0);
        check_eq("rst_mid_ballot", ballot, 0);
        check_eq("rst_mid_ready", vote_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | out_valid;
        end
        check_eq("rst_no_valid", seen, 0);

        // Fifth vote lands on the timer's expiry edge: completion wins.
        push_exp(5'b10110, 1'b0);
        vote(3'd0, 1'b0);
        vote(3'd1, 1'b1);
        vote(3'd2, 1'b1);
        vote(3'd3, 1'b0);
        repeat (12) tick();
        check_eq("edge_not_yet", out_valid, 0);
        vote(3'd4, 1'b1);
        check_eq("edge_valid", out_valid, 1);
        consume("edge");

        // One cycle too late: timeout first, late vote ignored.
        push_exp(5'b00110, 1'b1);
        vote(3'd0, 1'b0);
        vote(3'd1, 1'b1);
        vote(3'd2, 1'b1);
        vote(3'd3, 1'b0);
        repeat (13) tick();
        check_eq("late_valid", out_valid, 1);
        vote(3'd4, 1'b1);
        check_eq("late_err", err, 0);
        consume("late");

        check_eq("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vote_collector.md
VOTE_COLLECTOR -- requirements
Module: vote_collector

Interface
REQ-001 The block SHALL have parameter NUM_VOTERS, default 5, giving the ballot width; it is fixed at 5 to match the 5-bit majority stage.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the cycles allowed in COLLECT before the ballot is forced out.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 abort  input  1  synchronous clear of the ballot in progress.
REQ-006 vote_valid  input  1  a vote is offered this cycle.
REQ-007 vote_id  input  3  voter index; 0..4 are valid.
REQ-008 vote_bit  input  1  value of the vote.
REQ-009 vote_ready  output  1  the block can accept a vote.
REQ-010 ballot  output  5  bit i is voter i's vote; bits never received read 0; feeds the majority stage directly.
REQ-011 out_valid  output  1  ballot is complete and stable.
REQ-012 out_ready  input  1  downstream consumes the ballot.
REQ-013 timed_out  output  1  the presented ballot was forced out by timeout.
REQ-014 err  output  1  one-cycle pulse flagging a rejected vote.

Function
REQ-015 The block SHALL implement FSM states IDLE, COLLECT and PRESENT.
REQ-016 vote_ready SHALL be 1 in IDLE and COLLECT, and 0 in PRESENT.
REQ-017 A vote SHALL be accepted when vote_valid & vote_ready & vote_id<5 & !received[vote_id]; on acceptance, ballot[vote_id] takes vote_bit and received[vote_id] is set.
REQ-018 A vote SHALL be rejected when vote_valid & vote_ready and either vote_id>=5 or the voter is a duplicate; the vote is dropped and err=1 in the following cycle only.
REQ-019 vote_valid while vote_ready=0 SHALL be ignored, with no err.
REQ-020 IDLE SHALL move to COLLECT on an accepted vote; the timer clears to 0.
REQ-021 In COLLECT the timer SHALL increment every cycle.
REQ-022 On the edge whose accepted vote makes received all-ones, the block SHALL enter PRESENT with timed_out=0, so out_valid is high in the next cycle.
REQ-023 When the timer equals TIMEOUT_CYCLES-1 and the ballot is incomplete, the block SHALL enter PRESENT with timed_out=1.
REQ-024 If completion and timeout fall on the same edge, completion SHALL win and timed_out=0.
REQ-025 In PRESENT, out_valid SHALL be 1 and ballot and timed_out held stable until out_ready=1.
REQ-026 On out_valid & out_ready, the block SHALL return to IDLE and clear ballot, received, timed_out and the timer; the next vote is accepted no earlier than the following cycle.
REQ-027 abort=1 SHALL force IDLE and clear ballot, received, timer and timed_out in any state, with priority over all other events; a vote offered in the same cycle is not accepted and err is 0.
REQ-028 The timer width SHALL be clog2(TIMEOUT_CYCLES) and SHALL never wrap.

Reset
REQ-029 While reset_n=0, the block SHALL asynchronously hold state=IDLE, ballot=0, received=0, timer=0, out_valid=0, timed_out=0 and err=0; vote_ready=1 follows from IDLE.
REQ-030 Reset asserted mid-ballot or mid-PRESENT SHALL discard the ballot, with no out_valid afterwards.

Structure
REQ-031 Shared package lab3_pkg SHALL hold the state enum (IDLE/COLLECT/PRESENT) and NUM_VOTERS.
REQ-032 The timeout counter SHALL be a sub-module vote_timer with clear, enable and expired; all other logic stays in vote_collector.

Verification
REQ-033 Ids 0..4 with bits 1,0,1,1,0 on consecutive cycles -> ballot=5'b01101 (bit i = voter i), out_valid high the cycle after the fifth vote, timed_out=0.
REQ-034 Id 2 offered twice, then id 7 offered -> two err pulses, ballot[2] keeps its first value, and the timer still runs.
REQ-035 Votes for ids 0 and 1 only, then idle -> PRESENT after 16 COLLECT cycles, with timed_out=1 and ballot[4:2]=0.
REQ-036 out_ready held 0 for 10 cycles in PRESENT -> ballot stable, vote_ready=0, and votes offered are ignored with no err.
REQ-037 abort asserted during COLLECT with 3 votes received, then reset_n pulsed low during PRESENT -> IDLE each time, ballot=0, and out_valid never asserts for the aborted ballot.
REQ-038 Fifth vote accepted on the timer's expiry edge -> timed_out=0.
